// File: rtl/seven_segment_monitor.sv
// Passive seven-segment bus observer: synchronizes and debounces the segment lines,
// decodes committed glyphs to hex, and optionally checks that digits count up by one.
module seven_segment_monitor #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_c,
  input  logic       i_d,
  input  logic       i_e,
  input  logic       i_f,
  input  logic       i_g,
  input  logic       i_dp,
  input  logic       i_seq_en,
  input  logic       i_clear,
  output logic [3:0] o_data,
  output logic       o_dp,
  output logic       o_blank,
  output logic       o_error,
  output logic       o_valid,
  output logic [7:0] o_changes,
  output logic       o_seq_err
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  logic [7:0] pat_in;
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;
  logic [7:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] com_q, com_d;
  logic [3:0] data_q, data_d;
  logic       blank_q, blank_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;
  logic [7:0] changes_q, changes_d;
  logic       seq_err_q, seq_err_d;
  logic       base_vld_q, base_vld_d;
  logic [3:0] base_q, base_d;

  logic       commit;
  logic       seg_changed;
  logic [4:0] dec;

  assign pat_in = {i_dp, i_g, i_f, i_e, i_d, i_c, i_b, i_a};

  // Returns {legal, value}; blank and illegal both report legal = 0.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    sync1_d     = pat_in;
    sync2_d     = sync1_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    com_d       = com_q;
    data_d      = data_q;
    blank_d     = blank_q;
    err_d       = err_q;
    valid_d     = 1'b0;
    changes_d   = changes_q;
    seq_err_d   = seq_err_q;
    base_vld_d  = base_vld_q;
    base_d      = base_q;

    // Counter saturates at the threshold so long holds never wrap back below it.
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = 8'd1;
    end else if (cnt_q < STABLE_LIM) begin
      cnt_d = cnt_q + 8'd1;
    end

    commit      = (cnt_q >= STABLE_LIM) && (cand_q != com_q);
    seg_changed = (cand_q[6:0] != com_q[6:0]);
    dec         = decode_glyph(cand_q[6:0]);

    if (i_clear) begin
      seq_err_d  = 1'b0;
      base_vld_d = 1'b0;
    end

    if (commit) begin
      com_d     = cand_q;
      valid_d   = 1'b1;
      changes_d = changes_q + 8'd1;
      blank_d   = (cand_q[6:0] == 7'h00);
      err_d     = !dec[4] && (cand_q[6:0] != 7'h00);
      if (dec[4]) data_d = dec[3:0];

      if (i_seq_en && seg_changed) begin
        if (dec[4]) begin
          if (base_vld_q && (dec[3:0] != base_q + 4'd1) && !i_clear) seq_err_d = 1'b1;
          base_vld_d = 1'b1;
          base_d     = dec[3:0];
        end else if (cand_q[6:0] != 7'h00 && !i_clear) begin
          seq_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
      cand_q     <= 8'h00;
      cnt_q      <= 8'h00;
      com_q      <= 8'h00;
      data_q     <= 4'h0;
      blank_q    <= 1'b1;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      changes_q  <= 8'h00;
      seq_err_q  <= 1'b0;
      base_vld_q <= 1'b0;
      base_q     <= 4'h0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      com_q      <= com_d;
      data_q     <= data_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      changes_q  <= changes_d;
      seq_err_q  <= seq_err_d;
      base_vld_q <= base_vld_d;
      base_q     <= base_d;
    end
  end

  assign o_data    = data_q;
  assign o_dp      = com_q[7];
  assign o_blank   = blank_q;
  assign o_error   = err_q;
  assign o_valid   = valid_q;
  assign o_changes = changes_q;
  assign o_seq_err = seq_err_q;

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Randomized scoreboard bench for seven_segment_monitor: holds of segment patterns
// feed a behavioural model whose expected commits are checked on each o_valid.
module tb_seven_segment_monitor;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pat = 8'h00;
  logic       seq_en = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] o_data;
  logic       o_dp, o_blank, o_error, o_valid, o_seq_err;
  logic [7:0] o_changes;

  always #5 clk = ~clk;

  seven_segment_monitor #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .i_a(pat[0]), .i_b(pat[1]), .i_c(pat[2]), .i_d(pat[3]),
    .i_e(pat[4]), .i_f(pat[5]), .i_g(pat[6]), .i_dp(pat[7]),
    .i_seq_en(seq_en), .i_clear(clear),
    .o_data(o_data), .o_dp(o_dp), .o_blank(o_blank), .o_error(o_error),
    .o_valid(o_valid), .o_changes(o_changes), .o_seq_err(o_seq_err)
  );

  typedef struct packed {
    logic [3:0] data;
    logic       dp;
    logic       blank;
    logic       err;
    logic [7:0] chg;
    logic       seqerr;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [6:0] glyph [16];

  // Reference model state
  logic [7:0] m_com;
  logic [3:0] m_data;
  logic       m_blank, m_err, m_seqerr, m_seq_en;
  int         m_base;   // -1 = no baseline
  int         m_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int find_glyph(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (glyph[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_com = 8'h00; m_data = 4'h0; m_blank = 1'b1; m_err = 1'b0;
    m_seqerr = 1'b0; m_base = -1; m_total = 0;
  endtask

  task automatic model_commit(input logic [7:0] p);
    int v;
    bit seg_changed;
    exp_t e;
    if (p == m_com) return;
    seg_changed = (p[6:0] != m_com[6:0]);
    v = find_glyph(p[6:0]);
    m_com   = p;
    m_blank = (p[6:0] == 0);
    m_err   = (v < 0) && !m_blank;
    if (v >= 0) m_data = 4'(v);
    if (m_seq_en && seg_changed) begin
      if (v >= 0) begin
        if (m_base >= 0 && v != (m_base + 1) % 16) m_seqerr = 1'b1;
        m_base = v;
      end else if (m_err) begin
        m_seqerr = 1'b1;
      end
    end
    m_total++;
    e.data = m_data; e.dp = p[7]; e.blank = m_blank; e.err = m_err;
    e.chg = 8'(m_total); e.seqerr = m_seqerr;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; the pattern is sampled on exactly n rising edges.
  task automatic hold(input logic [7:0] p, input int n);
    pat = p;
    if (n >= S) model_commit(p);
    repeat (n) @(negedge clk);
  endtask

  // Only issued after a hold long enough that every pending commit has landed.
  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_seqerr = 1'b0;
    m_base = -1;
  endtask

  task automatic drain();
    int budget = 100;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_dp"}, o_dp, 0);
    chk({tag, "_blank"}, o_blank, 1);
    chk({tag, "_error"}, o_error, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_changes"}, o_changes, 0);
    chk({tag, "_seq_err"}, o_seq_err, 0);
  endtask

  function automatic logic [7:0] rand_pat(input logic [7:0] prev);
    logic [7:0] p;
    int r;
    do begin
      r = $urandom_range(0, 9);
      if (r <= 5)      p = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
      else if (r == 6) p = {1'($urandom_range(0, 1)), 7'h00};
      else             p = 8'($urandom_range(0, 255));
    end while (p == prev);
    return p;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e, a;
    if (!rst && o_valid) begin
      a = {o_data, o_dp, o_blank, o_error, o_changes, o_seq_err};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got %0h expected no o_valid", a);
      end else begin
        e = exp_q.pop_front();
        chk("commit", a, e);
      end
    end
  end

  initial begin
    int nvalid, first_edge, n;
    logic [7:0] prev;
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();
    m_seq_en = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Commit latency: change before edge 0, o_valid after edge S+2
    pat = 8'h06;
    model_commit(8'h06);
    nvalid = 0; first_edge = -1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (o_valid) begin
        nvalid++;
        if (first_edge < 0) first_edge = k;
      end
    end
    chk("latency_edge", first_edge, S + 2);
    chk("latency_pulses", nvalid, 1);
    @(negedge clk);
    chk("digit1_data", o_data, 1);
    chk("digit1_changes", o_changes, 1);

    // Short glitch and return to committed value
    hold(8'h5B, S - 1);
    hold(8'h06, 8);
    chk("glitch_data", o_data, 1);
    chk("glitch_changes", o_changes, 1);
    hold(8'h5B, 8);
    chk("digit2_data", o_data, 2);
    hold(8'h01, 8);
    chk("illegal_error", o_error, 1);
    chk("illegal_data_holds", o_data, 2);
    hold(8'h00, 8);
    chk("blank_blank", o_blank, 1);
    chk("blank_error", o_error, 0);

    // Counting sequence 0..F,0 with dp toggling every 4 cycles
    seq_en = 1'b1; m_seq_en = 1'b1;
    pulse_clear();
    for (int d = 0; d < 17; d++) begin
      hold({1'b0, glyph[d % 16]}, 4);
      hold({1'b1, glyph[d % 16]}, 4);
    end
    repeat (10) @(negedge clk);
    drain();
    chk("count_seq_err", o_seq_err, 0);
    hold(glyph[1], 8); hold(glyph[2], 8); hold(glyph[3], 8); hold(glyph[5], 8);
    chk("skip_seq_err", o_seq_err, 1);
    hold(glyph[6], 8); hold(8'h00, 8);
    chk("seq_err_sticky", o_seq_err, 1);
    pulse_clear();
    chk("seq_err_cleared", o_seq_err, 0);

    // Randomized holds; occasional clears and a seq_en-off tail
    prev = pat;
    for (int i = 0; i < 450; i++) begin
      if (i == 300) begin
        hold(prev, S + 5);
        seq_en = 1'b0; m_seq_en = 1'b0;
      end
      prev = rand_pat(prev);
      if ($urandom_range(0, 9) < 3) n = $urandom_range(1, S - 1);
      else n = $urandom_range(S, S + 4);
      hold(prev, n);
      if ($urandom_range(0, 19) == 0) begin
        hold(prev, S + 5);
        pulse_clear();
      end
    end
    hold(prev, S + 5);
    drain();
    chk("total_changes_wrap", o_changes, 8'(m_total));
    chk("enough_commits_to_wrap", (m_total >= 256), 1);

    // Reset during filtering of a new pattern
    hold(8'h06, S + 5);
    drain();
    pat = (m_com == 8'h5B) ? 8'h4F : 8'h5B;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midfilter_reset");
    model_reset();
    pat = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_reset_outputs("post_reset_blank");
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seven_segment_monitor.md
# seven_segment_monitor

Passive observer for a single active-high seven-segment display bus (segments a–g plus dp). It synchronizes the eight segment lines and filters out glitches. It then decodes each stable pattern back to a 4-bit hex value and flags unrecognized glyphs. An optional sequence checker verifies that successive digits count up by one modulo 16. The block sits on the board-test side of the display path: it checks that a display driver actually shows what it should, and it lets benches read back the displayed digit.

## Interface
- STABLE_CYCLES, 4, consecutive synchronized cycles a pattern must hold before it is committed; legal range 1–255.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_a, i_b, i_c, i_d, i_e, i_f, i_g  in  1 each  segment lines, 1 = lit, asynchronous to clk.
- i_dp  in  1  decimal point, 1 = lit.
- i_seq_en  in  1  enables the count-up sequence check.
- i_clear  in  1  synchronous; clears o_seq_err and the sequence baseline.
- o_data  out  4  last committed hex digit.
- o_dp  out  1  dp of the last committed pattern.
- o_blank  out  1  last committed segment field is all-off.
- o_error  out  1  last committed segment field is not a legal glyph.
- o_valid  out  1  one-cycle pulse on each commit.
- o_changes  out  8  commit counter, wraps 255 -> 0.
- o_seq_err  out  1  sticky sequence-violation flag.

## Operation
- The 8-bit pattern {dp,g,f,e,d,c,b,a} passes through a 2-flop synchronizer that resets to 0.
- Stability filter:
  - A candidate register plus a counter of consecutive equal synchronized samples.
  - Any sample differing from the candidate reloads the candidate and restarts the count.
- Commit condition: the candidate has held for STABLE_CYCLES samples and differs from the committed pattern. Each change commits exactly once.
- Legal glyphs, with segment field {g..a} -> value:
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
  - 7F->8, 6F->9, 77->A, 7C->b, 39->C, 5E->d, 79->E, 71->F
  - 00 -> blank
- On commit:
  - o_valid pulses and o_changes increments.
  - o_dp is updated.
  - Hex glyph: o_data = value, o_error = 0, o_blank = 0.
  - Blank: o_blank = 1, o_error = 0, o_data holds.
  - Illegal glyph: o_error = 1, o_blank = 0, o_data holds.
- Sequence check applies only when i_seq_en = 1 and the commit changed the segment field. dp-only commits are ignored.
  - No baseline yet: a hex commit becomes the baseline.
  - Hex commit with a baseline: it must equal baseline+1 mod 16, else o_seq_err is set. The commit becomes the new baseline either way.
  - Illegal-glyph commit: sets o_seq_err.
  - Blank commit: no effect.
- i_clear: o_seq_err = 0 and the baseline is invalidated on the next edge. If a commit lands in the same cycle, the clear wins over any error; a hex commit in that cycle becomes the new baseline.
- Reset state:
  - Committed pattern = 0x00, so o_blank = 1.
  - o_data = 0, o_dp = 0, o_error = 0, o_valid = 0, o_changes = 0, o_seq_err = 0.
  - No baseline; synchronizer, candidate and counter all zero.
  - Consequence: an all-off display after reset never commits.
- Reset mid-filtering discards the candidate; nothing is committed.

## Timing
- Input pattern changes before edge 0 and then holds: o_valid is high for the one cycle following edge STABLE_CYCLES+2, and o_data, o_dp, o_blank and o_error update at that same edge.
  - STABLE_CYCLES = 1: edge 3. Default 4: edge 6.
- A pattern held for fewer than STABLE_CYCLES cycles never commits.
- If the pattern returns to the committed value before the threshold: no commit.
- o_seq_err sets at the commit edge.
- Minimum spacing between o_valid pulses is STABLE_CYCLES cycles.
- Every output is a register; no combinational path from inputs to outputs.

## Test plan
- Reset, then drive 0x06 (digit 1) for 10 cycles with STABLE_CYCLES=4 -> o_valid pulses once after edge 6, o_data=1, o_blank=0, o_changes=1.
- Drive 0x5B for 3 cycles then revert to 0x06 -> no o_valid, outputs unchanged; a 0x5B hold of 4+ cycles -> o_data=2.
- Drive illegal 0x01 stably -> o_error=1, o_data holds its prior value. Then drive 0x00 -> o_blank=1, o_error=0.
- i_seq_en=1, drive digits 0..F then 0, each held 8 cycles, toggling dp every 4 cycles -> o_seq_err stays 0, and o_changes counts every segment and dp commit. Then skip 3→5 -> o_seq_err=1, which persists until i_clear.
- Drive 256 distinct commits -> o_changes wraps to 0.
- Assert rst during filtering of a new pattern -> all outputs return to reset values immediately; after release, a blank display produces no o_valid.
